// File: rtl/sci_series_engine.sv
// sci_series_engine: truncated power-series evaluator sum(c[m][k]*x^k) with a writable
// coefficient bank, valid/ready handshakes, convergence early-exit and synchronous flush.
module sci_series_engine #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int MAX_TERMS = 32,
  parameter int NUM_MODES = 4,
  localparam int DATA_WIDTH = 1 + EXP_W + MAN_W,
  localparam int RES_WIDTH = $clog2(MAX_TERMS + 1),
  localparam int MODE_W = $clog2(NUM_MODES),
  localparam int K_W = $clog2(MAX_TERMS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MODE_W-1:0]       in_mode,
  input  logic [RES_WIDTH-1:0]    in_res,
  input  logic [DATA_WIDTH-1:0]   in_x,
  input  logic [EXP_W-1:0]        eps_exp,
  input  logic                    coeff_wr_en,
  input  logic [MODE_W+K_W-1:0]   coeff_wr_addr,
  input  logic [DATA_WIDTH-1:0]   coeff_wr_data,
  output logic                    coeff_wr_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [RES_WIDTH-1:0]    out_terms,
  output logic                    busy
);
  localparam int M = MAN_W;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;
  localparam logic [DATA_WIDTH-1:0] ONE = {1'b0, EXP_W'(BIAS), {M{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(M-1){1'b0}}};
  localparam logic [RES_WIDTH-1:0] MAX_R = RES_WIDTH'(MAX_TERMS);
  typedef enum logic [1:0] {IDLE, LOAD, TERM, DONE} state_t;
  // n = {mantissa, guard, sticky}; round-to-nearest-even, then overflow to inf / underflow to zero
  function automatic logic [DATA_WIDTH-1:0] fp_round(input logic s, input int e_in, input logic [M+1:0] n);
    logic [M+1:0] r;
    int e;
    e = e_in;
    r = {2'b01, n[M+1:2]} + {{(M+1){1'b0}}, n[1] & (n[0] | n[2])};
    if (r[M+1]) e = e + 1;
    if (e >= EMAX) fp_round = {s, {EXP_W{1'b1}}, {M{1'b0}}};
    else if (e <= 0) fp_round = {s, {(DATA_WIDTH-1){1'b0}}};
    else fp_round = {s, e[EXP_W-1:0], r[M+1] ? r[M:1] : r[M-1:0]};
  endfunction
  function automatic logic [DATA_WIDTH-1:0] fp_mul(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic s, an, bn, ai, bi, az, bz;
    logic [2*M+1:0] p;
    int e;
    s = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
    an = (&a[DATA_WIDTH-2:M]) && (|a[M-1:0]);
    bn = (&b[DATA_WIDTH-2:M]) && (|b[M-1:0]);
    ai = (&a[DATA_WIDTH-2:M]) && !(|a[M-1:0]);
    bi = (&b[DATA_WIDTH-2:M]) && !(|b[M-1:0]);
    az = ~|a[DATA_WIDTH-2:M];
    bz = ~|b[DATA_WIDTH-2:M];
    p = {{(M+1){1'b0}}, 1'b1, a[M-1:0]} * {{(M+1){1'b0}}, 1'b1, b[M-1:0]};
    e = int'(a[DATA_WIDTH-2:M]) + int'(b[DATA_WIDTH-2:M]) - BIAS;
    if (p[2*M+1]) e = e + 1;
    else p = p << 1;
    if (an || bn || (ai && bz) || (bi && az)) fp_mul = QNAN;
    else if (ai || bi) fp_mul = {s, {EXP_W{1'b1}}, {M{1'b0}}};
    else if (az || bz) fp_mul = {s, {(DATA_WIDTH-1){1'b0}}};
    else fp_mul = fp_round(s, e, {p[2*M:M+1], p[M], |p[M-1:0]});
  endfunction
  function automatic logic [DATA_WIDTH-1:0] fp_add(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic an, bn, ai, bi, az, bz;
    logic [DATA_WIDTH-1:0] x, y;
    logic [M+3:0] xm, ym, n;
    logic [M+4:0] sum;
    int e, d;
    an = (&a[DATA_WIDTH-2:M]) && (|a[M-1:0]);
    bn = (&b[DATA_WIDTH-2:M]) && (|b[M-1:0]);
    ai = (&a[DATA_WIDTH-2:M]) && !(|a[M-1:0]);
    bi = (&b[DATA_WIDTH-2:M]) && !(|b[M-1:0]);
    az = ~|a[DATA_WIDTH-2:M];
    bz = ~|b[DATA_WIDTH-2:M];
    {x, y} = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? {a, b} : {b, a};
    e = int'(x[DATA_WIDTH-2:M]);
    d = e - int'(y[DATA_WIDTH-2:M]);
    xm = {1'b1, x[M-1:0], 3'b000};
    ym = {1'b1, y[M-1:0], 3'b000};
    // three extra bits (guard, round, sticky) keep the aligned addend exact enough for RNE
    ym = (d > M + 3) ? {{(M+3){1'b0}}, 1'b1}
       : ((ym >> d) | {{(M+3){1'b0}}, |(ym & ~({(M+4){1'b1}} << d))});
    if (x[DATA_WIDTH-1] == y[DATA_WIDTH-1]) begin
      sum = {1'b0, xm} + {1'b0, ym};
      if (sum[M+4]) begin
        n = sum[M+4:1] | {{(M+3){1'b0}}, sum[0]};
        e = e + 1;
      end else n = sum[M+3:0];
    end else begin
      n = xm - ym;
      for (int i = 0; i < M + 4; i++)
        if (!n[M+3] && n != '0) begin
          n = n << 1;
          e = e - 1;
        end
    end
    if (an || bn || (ai && bi && a[DATA_WIDTH-1] != b[DATA_WIDTH-1])) fp_add = QNAN;
    else if (ai) fp_add = a;
    else if (bi) fp_add = b;
    else if (az && bz) fp_add = {a[DATA_WIDTH-1] & b[DATA_WIDTH-1], {(DATA_WIDTH-1){1'b0}}};
    else if (az) fp_add = b;
    else if (bz) fp_add = a;
    else if (n == '0) fp_add = '0;
    else fp_add = fp_round(x[DATA_WIDTH-1], e, {n[M+2:3], n[2], |n[1:0]});
  endfunction
  state_t state;
  logic [DATA_WIDTH-1:0] bank [2 ** (MODE_W + K_W)];
  logic [MODE_W-1:0] mode_q;
  logic [RES_WIDTH-1:0] res_q, k;
  logic [DATA_WIDTH-1:0] x_q, xpow, acc, coef, prod;
  logic [1:0] lowcnt;
  logic low, conv, last;
  assign coef = bank[{mode_q, k[K_W-1:0]}];
  assign prod = fp_mul(coef, xpow);
  assign low = (eps_exp != '0) && (prod[DATA_WIDTH-2:M] < eps_exp);
  assign conv = low && lowcnt == 2'd1;
  assign last = (k + RES_WIDTH'(1)) == res_q;
  assign in_ready = state == IDLE;
  assign coeff_wr_ready = in_ready;
  assign busy = !in_ready;
  assign out_data = acc;
  assign out_terms = k;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= '0;
      res_q <= '0;
      x_q <= '0;
      xpow <= '0;
      acc <= '0;
      k <= '0;
      lowcnt <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          mode_q <= in_mode;
          res_q <= (in_res > MAX_R) ? MAX_R : in_res;
          x_q <= in_x;
          state <= LOAD;
        end
        LOAD: begin
          xpow <= ONE;
          acc <= '0;
          k <= '0;
          lowcnt <= '0;
          state <= (res_q == '0) ? DONE : TERM;
          out_valid <= res_q == '0;
        end
        TERM: begin
          acc <= fp_add(acc, prod);
          xpow <= fp_mul(xpow, x_q);
          k <= k + RES_WIDTH'(1);
          lowcnt <= low ? lowcnt + 2'd1 : 2'd0;
          state <= (last || conv) ? DONE : TERM;
          out_valid <= last || conv;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  // the bank is only writable while idle, so an evaluation never sees a coefficient change mid-run
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2 ** (MODE_W + K_W); i++) bank[i] <= '0;
    end else if (coeff_wr_en && coeff_wr_ready) bank[coeff_wr_addr] <= coeff_wr_data;
endmodule
